wci_cfg_sequencer: RTL

Sequences configuration and status accesses on the WCI slave port of the SM adapter (wciS0_* side). Accepts one command at a time from a local requester, drives it onto the OCP WCI request channel while honouring SThreadBusy, and waits for the single-beat response. Returns the response or a timeout status to the requester. It sits between a test/config controller and the adapter in the adapter top level, replacing free-running stimulus on MAddr/MData with ordered, acknowledged accesses.

---
 rtl/wci_cfg_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/wci_cfg_sequencer.sv
// Sequences single-beat WCI configuration/status accesses for a local requester,
// honouring SThreadBusy and bounding each wait for a response with a timeout.
module wci_cfg_sequencer #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              op_write,
  input  logic              op_space,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [31:0]       rsp_data,
  output logic              late_resp,
  output logic [2:0]        wci_MCmd,
  output logic              wci_MAddrSpace,
  output logic [3:0]        wci_MByteEn,
  output logic [ADDR_W-1:0] wci_MAddr,
  output logic [31:0]       wci_MData,
  input  logic [1:0]        wci_SResp,
  input  logic [31:0]       wci_SData,
  input  logic              wci_SThreadBusy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      op_ready       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_status     <= '0;
      rsp_data       <= '0;
      late_resp      <= 1'b0;
      wci_MCmd       <= '0;
      wci_MAddrSpace <= 1'b0;
      wci_MByteEn    <= '0;
      wci_MAddr      <= '0;
      wci_MData      <= '0;
    end else begin
      if (wci_SResp != 2'd0 && state != WAIT)
        late_resp <= 1'b1;

      case (state)
        IDLE: begin
          op_ready <= 1'b1;
          // The request registers double as the captured command.
          if (op_valid && op_ready) begin
            state          <= ISSUE;
            op_ready       <= 1'b0;
            wci_MCmd       <= op_write ? 3'd1 : 3'd2;
            wci_MAddrSpace <= op_space;
            wci_MByteEn    <= '1;
            wci_MAddr      <= op_addr;
            wci_MData      <= op_data;
          end
        end

        ISSUE: begin
          if (!wci_SThreadBusy) begin
            state          <= WAIT;
            timer          <= '0;
            wci_MCmd       <= '0;
            wci_MAddrSpace <= 1'b0;
            wci_MByteEn    <= '0;
            wci_MAddr      <= '0;
            wci_MData      <= '0;
          end
        end

        WAIT: begin
          // Timeout fires on the edge where the count would reach TIMEOUT.
          if (wci_SResp != 2'd0) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= wci_SResp - 2'd1;
            rsp_data   <= wci_SData;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= 2'd3;
            rsp_data   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            op_ready  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
